man_rx_fifo: RTL and testbench

//  Buffers 16-bit words from the Manchester decoder and presents them to the SPI_16bit slave's tx_data.

---
 rtl/man_link_pkg.sv | 15 +
 rtl/cs_edge_sync.sv | 30 +++
 rtl/man_rx_fifo.sv | 125 ++++++++++++
 tb/tb_man_rx_fifo.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/man_link_pkg.sv
// Shared types and constants for the Manchester receive link (decoder -> FIFO -> SPI slave).
package man_link_pkg;

  localparam int unsigned WORD_W = 16;
  localparam logic [3:0] STATUS_TAG = 4'hE;
  localparam logic [WORD_W-1:0] DEFAULT_EMPTY_WORD = 16'hFFFF;

  typedef logic [WORD_W-1:0] word_t;

  // Word shown to the SPI master when nothing is queued but status reporting is built in.
  function automatic word_t status_word(input logic ovf, input logic [7:0] cnt);
    return {STATUS_TAG, ovf, 3'b000, cnt};
  endfunction

endpackage

// File: rtl/cs_edge_sync.sv
// 2-FF synchronizer for an asynchronous pin plus a registered rising-edge pulse.
module cs_edge_sync (
  input  logic clk_in,
  input  logic rst,
  input  logic async_in,
  output logic sync_out,
  output logic rise_pulse
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Flops reset to 1 so an idle-high pin produces no edge after reset.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= async_in;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign sync_out   = r_sync;
  assign rise_pulse = r_sync & ~r_prev;

endmodule

// File: rtl/man_rx_fifo.sv
// Word FIFO between the Manchester decoder and the SPI_16bit slave; head pops on CS rising edge.
// Optional MAN_RX_STATUS_EN adds a saturating drop counter and a status word when empty.
module man_rx_fifo
  import man_link_pkg::*;
#(
  parameter int unsigned DEPTH      = 8,
  parameter word_t       EMPTY_WORD = DEFAULT_EMPTY_WORD
) (
  input  logic                     clk_in,
  input  logic                     rst,
  input  logic [WORD_W-1:0]        dec_data,
  input  logic                     dec_valid,
  input  logic                     spi_cs,
  input  logic                     ovf_clr,
  output logic [WORD_W-1:0]        tx_data,
  output logic                     empty,
  output logic                     full,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic          w_cs_sync;
  logic          w_pop_req;
  logic          w_pop;
  logic          w_wr;
  logic          w_drop;
  logic          w_ovf_nx;
  logic [AW-1:0] w_rd_nx;
  logic [LW-1:0] w_level_nx;
  word_t         w_empty_word;
  word_t         w_tx_nx;

  word_t         r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          r_empty;
  logic          r_full;
  logic          r_ovf;
  word_t         r_tx;

`ifdef MAN_RX_STATUS_EN
  logic [7:0]    r_drop_cnt;
  logic [7:0]    w_drop_cnt_nx;
`endif

  cs_edge_sync u_cs_sync (
    .clk_in     (clk_in),
    .rst        (rst),
    .async_in   (spi_cs),
    .sync_out   (w_cs_sync),
    .rise_pulse (w_pop_req)
  );

  always_comb begin
    w_pop      = w_pop_req & ~r_empty;
    // A pop in the same cycle frees a slot, so a write to a full FIFO still lands.
    w_wr       = dec_valid & (~r_full | w_pop);
    w_drop     = dec_valid & r_full & ~w_pop;
    w_rd_nx    = w_pop ? r_rd_ptr + AW'(1) : r_rd_ptr;
    w_level_nx = r_level + LW'(w_wr) - LW'(w_pop);
    w_ovf_nx   = w_drop | (r_ovf & ~ovf_clr);
`ifdef MAN_RX_STATUS_EN
    w_drop_cnt_nx = r_drop_cnt;
    if (w_drop) begin
      if (r_drop_cnt != 8'hFF) w_drop_cnt_nx = r_drop_cnt + 8'd1;
    end else if (ovf_clr) begin
      w_drop_cnt_nx = '0;
    end
    w_empty_word = status_word(w_ovf_nx, w_drop_cnt_nx);
`else
    w_empty_word = EMPTY_WORD;
`endif
    // The new head may be the word being written this cycle, which is not in r_mem yet.
    if (w_level_nx == '0)
      w_tx_nx = w_empty_word;
    else if (w_wr && (w_rd_nx == r_wr_ptr))
      w_tx_nx = dec_data;
    else
      w_tx_nx = r_mem[w_rd_nx];
  end

  always_ff @(posedge clk_in) begin
    if (w_wr) r_mem[r_wr_ptr] <= dec_data;
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
      r_ovf    <= 1'b0;
`ifdef MAN_RX_STATUS_EN
      r_drop_cnt <= '0;
      r_tx       <= status_word(1'b0, 8'h00);
`else
      r_tx       <= EMPTY_WORD;
`endif
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      r_rd_ptr <= w_rd_nx;
      r_level  <= w_level_nx;
      r_empty  <= (w_level_nx == '0);
      r_full   <= (w_level_nx == LW'(DEPTH));
      r_ovf    <= w_ovf_nx;
`ifdef MAN_RX_STATUS_EN
      r_drop_cnt <= w_drop_cnt_nx;
`endif
      // tx_data is frozen while CS is low so the slave sees a stable word for the whole frame.
      if (w_cs_sync) r_tx <= w_tx_nx;
    end
  end

  assign tx_data  = r_tx;
  assign empty    = r_empty;
  assign full     = r_full;
  assign overflow = r_ovf;
  assign level    = r_level;

endmodule

// File: tb/tb_man_rx_fifo.sv
// Scoreboard bench for man_rx_fifo: queued words are compared against tx_data as CS pulses pop them.
module tb_man_rx_fifo;

  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] dec_data = '0;
  logic        dec_valid = 1'b0;
  logic        spi_cs = 1'b1;
  logic        ovf_clr = 1'b0;
  logic [15:0] tx_data;
  logic        empty;
  logic        full;
  logic        overflow;
  logic [3:0]  level;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] sb[$];
  logic        m_ovf = 1'b0;
  logic [7:0]  m_cnt = '0;

  man_rx_fifo #(.DEPTH(DEPTH), .EMPTY_WORD(16'hFFFF)) dut (
    .clk_in    (clk),
    .rst       (rst),
    .dec_data  (dec_data),
    .dec_valid (dec_valid),
    .spi_cs    (spi_cs),
    .ovf_clr   (ovf_clr),
    .tx_data   (tx_data),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .level     (level)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] exp_empty();
`ifdef MAN_RX_STATUS_EN
    return {4'hE, m_ovf, 3'b000, m_cnt};
`else
    return 16'hFFFF;
`endif
  endfunction

  function automatic logic [15:0] exp_tx();
    if (sb.size() > 0) return sb[0];
    return exp_empty();
  endfunction

  function automatic logic [3:0] exp_level();
    return 4'(sb.size());
  endfunction

  // All stimulus tasks start and end on a falling clock edge.
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sb.delete();
    m_ovf = 1'b0;
    m_cnt = '0;
  endtask

  task automatic model_write(input logic [15:0] d);
    if (sb.size() < DEPTH) sb.push_back(d);
    else begin
      m_ovf = 1'b1;
      if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
    end
  endtask

  task automatic do_write(input logic [15:0] d);
    dec_data  = d;
    dec_valid = 1'b1;
    @(negedge clk);
    dec_valid = 1'b0;
    model_write(d);
  endtask

  task automatic cs_pulse();
    spi_cs = 1'b0;
    repeat (4) @(negedge clk);
    spi_cs = 1'b1;
    repeat (3) @(negedge clk);
    if (sb.size() > 0) void'(sb.pop_front());
  endtask

  // dec_valid lands on the same clock edge that executes the pop.
  task automatic write_on_pop(input logic [15:0] d);
    spi_cs = 1'b0;
    repeat (4) @(negedge clk);
    spi_cs = 1'b1;
    repeat (2) @(negedge clk);
    dec_data  = d;
    dec_valid = 1'b1;
    @(negedge clk);
    dec_valid = 1'b0;
    if (sb.size() > 0) void'(sb.pop_front());
    model_write(d);
  endtask

  task automatic clear_ovf();
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    m_ovf = 1'b0;
    m_cnt = '0;
  endtask

  task automatic test_reset();
    spi_cs = 1'b1;
    do_reset();
    n_tests++; if (tx_data !== exp_tx()) begin n_fail++; $display("FAIL reset_tx: got %h want %h", tx_data, exp_tx()); end
    n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", empty); end
    n_tests++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", full); end
    n_tests++; if (level !== 4'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", level); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", overflow); end
  endtask

  task automatic test_basic();
    do_reset();
    do_write(16'h1234);
    do_write(16'hABCD);
    n_tests++; if (tx_data !== 16'h1234) begin n_fail++; $display("FAIL basic_head: got %h want 1234", tx_data); end
    n_tests++; if (level !== 4'd2) begin n_fail++; $display("FAIL basic_level2: got %0d want 2", level); end
    cs_pulse();
    n_tests++; if (tx_data !== 16'hABCD) begin n_fail++; $display("FAIL basic_pop1: got %h want abcd", tx_data); end
    n_tests++; if (level !== 4'd1) begin n_fail++; $display("FAIL basic_level1: got %0d want 1", level); end
    cs_pulse();
    n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL basic_empty: got %b want 1", empty); end
    n_tests++; if (tx_data !== exp_tx()) begin n_fail++; $display("FAIL basic_empty_tx: got %h want %h", tx_data, exp_tx()); end
    cs_pulse();
    n_tests++; if (level !== 4'd0) begin n_fail++; $display("FAIL basic_pop_empty_level: got %0d want 0", level); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL basic_pop_empty_ovf: got %b want 0", overflow); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 9; i++) do_write(16'h1000 + 16'(i));
    n_tests++; if (full !== 1'b1) begin n_fail++; $display("FAIL ovf_full: got %b want 1", full); end
    n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    n_tests++; if (level !== 4'd8) begin n_fail++; $display("FAIL ovf_level: got %0d want 8", level); end
    for (int i = 0; i < 8; i++) begin
      n_tests++; if (tx_data !== exp_tx()) begin n_fail++; $display("FAIL ovf_order[%0d]: got %h want %h", i, tx_data, exp_tx()); end
      cs_pulse();
    end
    n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL ovf_drained: got %b want 1", empty); end
    n_tests++; if (tx_data !== exp_tx()) begin n_fail++; $display("FAIL ovf_drained_tx: got %h want %h", tx_data, exp_tx()); end
    clear_ovf();
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b want 0", overflow); end
  endtask

  task automatic test_full_pop();
    do_reset();
    for (int i = 0; i < 8; i++) do_write(16'h2000 + 16'(i));
    write_on_pop(16'h2BAD);
    n_tests++; if (level !== 4'd8) begin n_fail++; $display("FAIL fullpop_level: got %0d want 8", level); end
    n_tests++; if (full !== 1'b1) begin n_fail++; $display("FAIL fullpop_full: got %b want 1", full); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fullpop_ovf: got %b want 0", overflow); end
    for (int i = 0; i < 8; i++) begin
      n_tests++; if (tx_data !== exp_tx()) begin n_fail++; $display("FAIL fullpop_order[%0d]: got %h want %h", i, tx_data, exp_tx()); end
      cs_pulse();
    end
    n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL fullpop_drained: got %b want 1", empty); end
  endtask

  task automatic test_empty_pop();
    do_reset();
    write_on_pop(16'h5A5A);
    n_tests++; if (level !== 4'd1) begin n_fail++; $display("FAIL emptypop_level: got %0d want 1", level); end
    n_tests++; if (tx_data !== 16'h5A5A) begin n_fail++; $display("FAIL emptypop_tx: got %h want 5a5a", tx_data); end
    // One live word: pop and write together must leave the new word as head.
    write_on_pop(16'h6B6B);
    n_tests++; if (tx_data !== 16'h6B6B) begin n_fail++; $display("FAIL onepop_tx: got %h want 6b6b", tx_data); end
    n_tests++; if (level !== 4'd1) begin n_fail++; $display("FAIL onepop_level: got %0d want 1", level); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 2) != 2) do_write(16'($urandom));
      else cs_pulse();
      n_tests++; if (tx_data !== exp_tx()) begin n_fail++; $display("FAIL rand_tx[%0d]: got %h want %h", i, tx_data, exp_tx()); end
      n_tests++; if (level !== exp_level()) begin n_fail++; $display("FAIL rand_level[%0d]: got %0d want %0d", i, level, exp_level()); end
      n_tests++; if (overflow !== m_ovf) begin n_fail++; $display("FAIL rand_ovf[%0d]: got %b want %b", i, overflow, m_ovf); end
    end
  endtask

  task automatic test_status();
    do_reset();
    for (int i = 0; i < 11; i++) do_write(16'h3000 + 16'(i));
    for (int i = 0; i < 8; i++) cs_pulse();
    n_tests++; if (tx_data !== exp_tx()) begin n_fail++; $display("FAIL status_drops_tx: got %h want %h", tx_data, exp_tx()); end
    n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL status_ovf: got %b want 1", overflow); end
    clear_ovf();
    n_tests++; if (tx_data !== exp_tx()) begin n_fail++; $display("FAIL status_clr_tx: got %h want %h", tx_data, exp_tx()); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL status_clr_ovf: got %b want 0", overflow); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) do_write(16'h4000 + 16'(i));
    spi_cs = 1'b0;
    repeat (2) @(negedge clk);
    do_reset();
    repeat (3) @(negedge clk);
    spi_cs = 1'b1;
    repeat (4) @(negedge clk);
    n_tests++; if (level !== 4'd0) begin n_fail++; $display("FAIL midrst_level: got %0d want 0", level); end
    n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL midrst_empty: got %b want 1", empty); end
    n_tests++; if (tx_data !== exp_tx()) begin n_fail++; $display("FAIL midrst_tx: got %h want %h", tx_data, exp_tx()); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_overflow();
    test_full_pop();
    test_empty_pop();
    test_random();
    test_status();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
